// File: rtl/wb_ram_slave_ctrl.sv
// wb_ram_slave_ctrl
// Wishbone B4 slave front-end for the single-port-read / byte-write block RAM
// wrapper. Converts classic and incrementing-burst Wishbone cycles into RAM
// write enables, addresses and data, and times wb_ack_o against the RAM's
// one-clock read latency.
//
// Optional feature macro: WB_RAM_BURST_EN
//   defined   - BURST state with next-address prediction; cti=010 beats take
//               one cycle each after the first.
//   undefined - cti/bte ignored; every beat is a two-cycle IDLE->ACK access.
//
// Ports
//   wb_clk_i            clock shared with the RAM
//   wb_rst_i            synchronous active-high reset
//   wb_adr_i[31:0]      byte address (word index = wb_adr_i[aw+1:2])
//   wb_dat_i[31:0]      write data
//   wb_sel_i[3:0]       byte selects
//   wb_we_i             write enable
//   wb_cyc_i, wb_stb_i  cycle valid / strobe
//   wb_cti_i[2:0]       cycle type (000 classic, 010 incr burst, 111 end)
//   wb_bte_i[1:0]       burst wrap (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
//   wb_dat_o[31:0]      read data (= ram_dout)
//   wb_ack_o            cycle acknowledge
//   ram_we[3:0]         RAM byte write enables
//   ram_din[31:0]       RAM write data (= wb_dat_i)
//   ram_waddr[aw-1:0]   RAM write address (= word index)
//   ram_raddr[aw-1:0]   RAM read address (combinational)
//   ram_dout[31:0]      RAM read data, one clock after ram_raddr
module wb_ram_slave_ctrl #(
    parameter int unsigned depth = 4096,
    localparam int unsigned aw = $clog2(depth)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic [3:0]    ram_we,
    output logic [31:0]   ram_din,
    output logic [aw-1:0] ram_waddr,
    output logic [aw-1:0] ram_raddr,
    input  logic [31:0]   ram_dout
);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_ack   = 2'd1;
`ifdef WB_RAM_BURST_EN
    localparam logic [1:0] st_burst = 2'd2;
    localparam logic [2:0] cti_incr = 3'b010;
`endif

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          req;
    logic [aw-1:0] word_idx;
    logic          unused_ok;

    assign req       = wb_cyc_i & wb_stb_i;
    assign word_idx  = wb_adr_i[aw+1:2];
    assign ram_waddr = word_idx;
    assign ram_din   = wb_dat_i;
    assign wb_dat_o  = ram_dout;

    // Address bits outside the word index carry no meaning for this RAM.
`ifdef WB_RAM_BURST_EN
    assign unused_ok = ^{wb_adr_i[31:aw+2], wb_adr_i[1:0]};
`else
    assign unused_ok = ^{wb_adr_i[31:aw+2], wb_adr_i[1:0], wb_cti_i, wb_bte_i};
`endif

`ifdef WB_RAM_BURST_EN
    logic [aw-1:0] idx_inc;
    logic [aw-1:0] wrap_mask;
    logic [aw-1:0] burst_next;

    // Prefetch address for the following beat: only the bits inside the
    // wrap window advance; linear bursts wrap at the top of the RAM.
    always_comb begin
        idx_inc = (word_idx == aw'(depth - 1)) ? '0 : word_idx + aw'(1);
        case (wb_bte_i)
            2'b01:   wrap_mask = aw'(3);
            2'b10:   wrap_mask = aw'(7);
            2'b11:   wrap_mask = aw'(15);
            default: wrap_mask = '1;
        endcase
        burst_next = (word_idx & ~wrap_mask) | (idx_inc & wrap_mask);
    end
`endif

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and RAM / ack outputs.
    always_comb begin
        state_nxt = state;
        wb_ack_o  = 1'b0;
        ram_we    = 4'b0000;
        ram_raddr = word_idx;

        case (state)
            st_idle: begin
                if (req && wb_we_i) begin
                    ram_we = wb_sel_i;
                end
                if (req) begin
`ifdef WB_RAM_BURST_EN
                    state_nxt = (wb_cti_i == cti_incr) ? st_burst : st_ack;
`else
                    state_nxt = st_ack;
`endif
                end
            end

            // Read data for the held address is on ram_dout this cycle.
            st_ack: begin
                wb_ack_o  = 1'b1;
                state_nxt = st_idle;
            end

`ifdef WB_RAM_BURST_EN
            // Data for the current beat was fetched last cycle; fetch the
            // next beat now so every cycle can acknowledge.
            st_burst: begin
                wb_ack_o  = req;
                ram_raddr = burst_next;
                if (req && wb_we_i) begin
                    ram_we = wb_sel_i;
                end
                if (!req || (wb_cti_i != cti_incr)) begin
                    state_nxt = st_idle;
                end
            end
`endif

            default: begin
                state_nxt = st_idle;
            end
        endcase

        // Reset drops any pending beat and blocks RAM writes.
        if (wb_rst_i) begin
            wb_ack_o = 1'b0;
            ram_we   = 4'b0000;
        end
    end

endmodule

// File: tb/tb_wb_ram_slave_ctrl.sv
// Testbench for wb_ram_slave_ctrl: a Wishbone master issues directed and
// random classic / burst transfers; a transaction-level model predicts ack,
// write enables, read address and read data, compared every cycle.
`timescale 1ns/1ps
module tb_wb_ram_slave_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
`ifdef WB_RAM_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          wb_rst_i;
    logic [31:0]   wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [3:0]    ram_we;
    logic [31:0]   ram_din;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_dout;

    always #5 clk = ~clk;

    wb_ram_slave_ctrl #(.depth(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cti_i  (wb_cti_i),
        .wb_bte_i  (wb_bte_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout)
    );

    // Block RAM stand-in: byte writes, one-clock registered read.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= ram[ram_raddr];
    end

    // Reference model state: expected memory contents and transfer phase.
    logic [31:0] mem_ref [DEPTH];
    bit ack_due;     // a classic beat was accepted last cycle
    bit streaming;   // inside a single-cycle-beat burst
    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic [3:0]  wr_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nxt(input int idx, input logic [1:0] bte);
        int n;
        if (bte == 2'b00) return (idx + 1) % DEPTH;
        n = 2 << bte;
        return idx - (idx % n) + ((idx + 1) % n);
    endfunction

    // Expected ack / write enables / read address for the current cycle.
    function automatic void predict(output bit a, output logic [3:0] w, output int r);
        int idx = int'(wb_adr_i[AW+1:2]);
        bit req = wb_cyc_i & wb_stb_i;
        a = 1'b0;
        w = 4'b0000;
        r = idx;
        if (wb_rst_i) return;
        if (ack_due) begin
            a = 1'b1;
        end else begin
            if (req && wb_we_i) w = wb_sel_i;
            if (streaming) begin
                a = req;
                r = nxt(idx, wb_bte_i);
            end
        end
    endfunction

    // Model update at the active edge.
    always @(posedge clk) begin
        bit a;
        logic [3:0] w;
        int r;
        int idx;
        bit req;
        predict(a, w, r);
        idx = int'(wb_adr_i[AW+1:2]);
        req = wb_cyc_i & wb_stb_i;
        for (int b = 0; b < 4; b++)
            if (w[b]) mem_ref[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        if (wb_rst_i) begin
            ack_due   <= 1'b0;
            streaming <= 1'b0;
        end else if (ack_due) begin
            ack_due <= 1'b0;
        end else if (streaming) begin
            streaming <= req && (wb_cti_i == 3'b010);
        end else if (req) begin
            if (BURST_ON && wb_cti_i == 3'b010) streaming <= 1'b1;
            else                                ack_due   <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit a;
        logic [3:0] w;
        int r;
        predict(a, w, r);
        chk("wb_ack_o", 32'(wb_ack_o), 32'(a));
        chk("ram_we", 32'(ram_we), 32'(w));
        if (!wb_rst_i) chk("ram_raddr", 32'(ram_raddr), 32'(r));
        if (w != 4'b0000) begin
            chk("ram_waddr", 32'(ram_waddr), 32'(wb_adr_i[AW+1:2]));
            chk("ram_din", ram_din, wb_dat_i);
        end
        if (a && !wb_we_i) chk("wb_dat_o", wb_dat_o, mem_ref[int'(wb_adr_i[AW+1:2])]);
    end

    task automatic wait_ack(input string name, output logic [31:0] d, output int t);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wb_ack_o && t < 10);
        if (!wb_ack_o) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: ack timeout, got no ack expected ack within 10 cycles", name);
        end
        d = wb_dat_o;
    endtask

    // One master transfer: n beats from word start; burst selects cti 010/111.
    task automatic xfer(input bit we, input int start, input int n, input logic [1:0] bte,
                        input bit burst, input int stall_at, output int total);
        int idx = start;
        int t;
        logic [31:0] d;
        total = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = we;
            wb_adr_i = ($urandom & ~32'(DEPTH*4 - 4)) | 32'(idx*4);
            wb_sel_i = we ? wr_sel : 4'($urandom);
            wb_dat_i = we ? wr_data[k] : $urandom;
            wb_cti_i = !burst ? 3'b000 : (k == n-1) ? 3'b111 : 3'b010;
            wb_bte_i = bte;
            wait_ack("xfer_ack", d, t);
            rd_data[k] = d;
            total += t;
            if (k == stall_at && k < n-1) begin
                @(posedge clk); #1;
                wb_stb_i = 1'b0;
            end
            idx = nxt(idx, bte);
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        logic [31:0] d;
        int exp_wrap [4] = '{6, 7, 4, 5};

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = '0;
            mem_ref[i] = '0;
        end

        // Reset held two cycles with a write request pending.
        wb_rst_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_sel_i = 4'b1111;
        wb_adr_i = 32'(16*4);
        wb_dat_i = 32'h0;
        wb_cti_i = 3'b000;
        wb_bte_i = 2'b00;
        repeat (2) @(posedge clk);
        #1 wb_rst_i = 1'b0;
        wait_ack("reset_release", d, t);
        chk("reset_first_ack_cycles", 32'(t), 32'd2);
        @(posedge clk); #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        // Classic byte write then read on zeroed RAM.
        wr_sel     = 4'b0100;
        wr_data[0] = 32'hA5A5A5A5;
        xfer(1'b1, 4, 1, 2'b00, 1'b0, -1, t);
        chk("classic_write_cycles", 32'(t), 32'd2);
        xfer(1'b0, 4, 1, 2'b00, 1'b0, -1, t);
        chk("classic_read_cycles", 32'(t), 32'd2);
        chk("classic_read_data", rd_data[0], 32'h00A50000);

        // Preload every word with a recognisable pattern.
        wr_sel = 4'b1111;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data[0] = 32'h1000_0000 + 32'(i);
            xfer(1'b1, i, 1, 2'b00, 1'b0, -1, t);
        end

        // Linear 4-beat burst read from word 8.
        xfer(1'b0, 8, 4, 2'b00, 1'b1, -1, t);
        chk("linear_burst_cycles", 32'(t), BURST_ON ? 32'd5 : 32'd8);
        for (int k = 0; k < 4; k++)
            chk("linear_burst_data", rd_data[k], 32'h1000_0008 + 32'(k));

        // Wrap-4 burst from word 6.
        xfer(1'b0, 6, 4, 2'b01, 1'b1, -1, t);
        for (int k = 0; k < 4; k++)
            chk("wrap4_burst_data", rd_data[k], 32'h1000_0000 + 32'(exp_wrap[k]));

        // Strobe dropped after the second beat.
        xfer(1'b0, 8, 4, 2'b00, 1'b1, 1, t);
        chk("stall_burst_cycles", 32'(t), BURST_ON ? 32'd6 : 32'd8);
        for (int k = 0; k < 4; k++)
            chk("stall_burst_data", rd_data[k], 32'h1000_0008 + 32'(k));

        // Linear burst wrapping past the top of the RAM.
        xfer(1'b0, DEPTH-2, 4, 2'b00, 1'b1, -1, t);
        for (int k = 0; k < 4; k++)
            chk("top_wrap_data", rd_data[k], 32'h1000_0000 + 32'((DEPTH - 2 + k) % DEPTH));

        // Random mix of classic and burst reads/writes.
        for (int it = 0; it < 60; it++) begin
            bit we    = 1'($urandom_range(0, 1));
            bit burst = 1'($urandom_range(0, 1));
            int n     = burst ? int'($urandom_range(1, 6)) : 1;
            int stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n-1)) : -1;
            wr_sel = 4'($urandom_range(1, 15));
            for (int k = 0; k < 16; k++) wr_data[k] = $urandom;
            xfer(we, int'($urandom_range(0, DEPTH-1)), n, 2'($urandom_range(0, 3)),
                 burst, stall, t);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ram_slave_ctrl.md
# wb_ram_slave_ctrl

Wishbone B4 slave front-end that sits directly upstream of the block-RAM wrapper `wb_ram_generic` in the picorv32 SoC. It turns Wishbone classic and incrementing-burst cycles into the RAM's byte-write-enable, write-address, read-address and write-data signals. It returns RAM read data with a correctly timed `wb_ack_o`. The RAM read port has one clock of latency.

## Interface
- `depth`, default 4096: RAM size in 32-bit words; `aw = $clog2(depth)`.
- `wb_clk_i` in 1: single clock, shared with the RAM.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wb_adr_i` in 32: byte address; word index is `wb_adr_i[aw+1:2]`, all other bits ignored.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte selects.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: cycle valid.
- `wb_stb_i` in 1: strobe.
- `wb_cti_i` in 3: cycle type. 000 = classic, 010 = incrementing burst, 111 = end of burst.
- `wb_bte_i` in 2: burst wrap. 00 = linear, 01 = wrap-4, 10 = wrap-8, 11 = wrap-16.
- `wb_dat_o` out 32: read data, equal to `ram_dout`.
- `wb_ack_o` out 1: cycle acknowledge.
- `ram_we` out 4: byte write enables to the RAM.
- `ram_din` out 32: write data, equal to `wb_dat_i`.
- `ram_waddr` out aw: equal to the word index.
- `ram_raddr` out aw: RAM read address, combinational.
- `ram_dout` in 32: RAM read data, valid one clock after `ram_raddr`.

## Operation
- `req = wb_cyc_i & wb_stb_i`.
- States: IDLE, ACK, BURST. BURST exists only with the macro defined (see Configuration).
- **IDLE**
  - `ram_raddr` = word index.
  - `ram_we` = `wb_sel_i` if `req & wb_we_i`, else 0.
  - `wb_ack_o` = 0.
  - On `req`: go to BURST if the macro is defined and `wb_cti_i == 010`; otherwise go to ACK.
- **ACK**
  - `wb_ack_o` = 1.
  - `ram_we` = 0.
  - `ram_raddr` holds the word index, so `wb_dat_o` shows the data of the request.
  - Always returns to IDLE.
- **BURST**
  - `wb_ack_o = req`.
  - `ram_we` = `wb_sel_i` if `req & wb_we_i`, else 0.
  - `ram_raddr = next(word index)`, where `next` increments by 1 within the `wb_bte_i` window:
    - linear wraps modulo `depth`;
    - wrap-N increments only the low log2(N) bits.
  - Exits to IDLE on any of: `~req`, `wb_cti_i == 111`, or `wb_cti_i != 010`.
- A master that drops `wb_stb_i` mid-burst restarts from IDLE; the next beat gets the two-cycle classic latency.
- The master must present the address that `next` predicts; the block does not check it.
- Read of a word written in the immediately preceding cycle returns the RAM's read-during-write value. This is not guaranteed.

## Timing
- Reset values:
  - state = IDLE;
  - `wb_ack_o` = 0;
  - `ram_we` = 0 while `wb_rst_i` is high, even if `req` is high.
  - `wb_dat_o`, `ram_din`, `ram_waddr` and `ram_raddr` are combinational and have no reset value.
- Classic write: `ram_we` pulses in the request cycle only; `wb_ack_o` follows one cycle later; two cycles per access.
- Classic read: address is presented in cycle 0; `wb_ack_o` and valid `wb_dat_o` come in cycle 1; two cycles per access.
- Burst: first ack in cycle 1, then one ack per cycle. N beats complete in N+1 cycles.
- Back-to-back classic requests: IDLE is re-entered between them, so there is no ack in the cycle after ACK.
- Reset during ACK or BURST: the cycle after reset shows `wb_ack_o = 0` and state IDLE. The pending beat is dropped, and no RAM write happens in the reset cycle.
- `wb_cyc_i` low in any state forces the return to IDLE on the next edge.

## Configuration
- `WB_RAM_BURST_EN`
  - Defined: the BURST state and address prediction are compiled in, and `cti = 010` cycles get single-cycle beats.
  - Undefined: `wb_cti_i` and `wb_bte_i` are ignored, every access uses IDLE→ACK, and a burst degrades to two cycles per beat. This remains legal Wishbone.

## Test plan
- **Reset.** Assert `wb_rst_i` for 2 cycles with `req` high and `we = 1`, `sel = 1111` → `ram_we` = 0000 and `wb_ack_o` = 0 throughout. The first ack arrives 2 cycles after release.
- **Classic byte write and read.** Write 0xA5A5A5A5 to byte address 0x10 with `sel = 0100`, then read 0x10 → `ram_we` = 0100 for one cycle, ack one cycle later. The read returns 0x00A50000 on a zeroed RAM, with ack in cycle 1.
- **Linear burst read (macro on).** Read 4 beats from word 8, with `cti = 010,010,010,111` → acks in cycles 1–4. `ram_raddr` sequence is 8, 9, 10, 11, 12. Back in IDLE in cycle 5.
- **Wrap-4 burst (macro on).** Read starting at word 6 with `bte = 01` → data from words 6, 7, 4, 5.
- **Stall mid-burst.** Drop `wb_stb_i` after beat 2 → ack low in that cycle. On re-assertion, the next ack comes 1 cycle later (classic latency). The data is correct.
- **Macro off.** Run the same 4-beat burst as above → 4 acks over 8 cycles, identical data.
